// File: rtl/comm_pkg.sv
// Shared types and constants for the serial command link.
// Used by both the command transmitter and the receive path.
package comm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW,
    RESP
  } comm_state_t;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_NACK = 8'h5A;

  localparam int unsigned DFLT_TIMEOUT  = 5_000_000;
  localparam int unsigned DFLT_BAUD_DIV = 2604;

endpackage

// File: rtl/UART.sv
// 8N1 UART core: one transmitter, one receiver, shared baud divisor.
// tx_done is sticky until the next trmt; rx_rdy holds until cleared.
module UART #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  input  logic       clr_rx_rdy,
  output logic       rx_rdy,
  output logic [7:0] rx_data
);

  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  logic [9:0]    tx_shft_q;
  logic [BW-1:0] tx_baud_q;
  logic [3:0]    tx_bit_q;
  logic          tx_busy_q;
  logic          tx_done_q;
  logic          tx_shift;

  logic          rx_s1_q;
  logic          rx_s2_q;
  logic          rx_busy_q;
  logic [BW-1:0] rx_baud_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_shft_q;
  logic          rx_rdy_q;
  logic          rx_samp;
  logic          rx_start;

  assign tx_shift = tx_busy_q && (tx_baud_q == BAUD_LAST);
  assign TX       = tx_shft_q[0];
  assign tx_done  = tx_done_q;

  // Transmit shifter: start, 8 data bits LSB first, stop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shft_q <= '1;
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b0;
    end else if (trmt) begin
      tx_shft_q <= {1'b1, tx_data, 1'b0};
      tx_baud_q <= '0;
      tx_bit_q  <= '0;
      tx_busy_q <= 1'b1;
    end else if (tx_busy_q) begin
      if (tx_shift) begin
        tx_baud_q <= '0;
        tx_shft_q <= {1'b1, tx_shft_q[9:1]};
        tx_bit_q  <= tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9)
          tx_busy_q <= 1'b0;
      end else begin
        tx_baud_q <= tx_baud_q + BW'(1);
      end
    end
  end

  // Sticky done flag: set at end of stop bit, cleared by trmt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tx_done_q <= 1'b0;
    else if (trmt)
      tx_done_q <= 1'b0;
    else if (tx_shift && (tx_bit_q == 4'd9))
      tx_done_q <= 1'b1;
  end

  assign rx_samp  = rx_busy_q && (rx_baud_q == '0);
  assign rx_start = !rx_busy_q && !rx_s2_q;
  assign rx_data  = rx_shft_q;
  assign rx_rdy   = rx_rdy_q;

  // Two-flop synchronizer on the asynchronous RX line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  // Receive sampler: mid-bit samples, rejects a glitch start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_busy_q <= 1'b0;
      rx_baud_q <= '0;
      rx_bit_q  <= '0;
      rx_shft_q <= '0;
    end else if (rx_start) begin
      rx_busy_q <= 1'b1;
      rx_baud_q <= BAUD_HALF;
      rx_bit_q  <= '0;
    end else if (rx_samp) begin
      rx_baud_q <= BAUD_LAST;
      rx_bit_q  <= rx_bit_q + 4'd1;
      if ((rx_bit_q >= 4'd1) && (rx_bit_q <= 4'd8))
        rx_shft_q <= {rx_s2_q, rx_shft_q[7:1]};
      if ((rx_bit_q == 4'd9) || ((rx_bit_q == 4'd0) && rx_s2_q))
        rx_busy_q <= 1'b0;
    end else if (rx_busy_q) begin
      rx_baud_q <= rx_baud_q - BW'(1);
    end
  end

  // Ready flag: set on stop-bit sample, cleared by consumer or new frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rx_rdy_q <= 1'b0;
    else if (rx_samp && (rx_bit_q == 4'd9))
      rx_rdy_q <= 1'b1;
    else if (clr_rx_rdy || rx_start)
      rx_rdy_q <= 1'b0;
  end

endmodule

// File: rtl/remote_cmd_tx.sv
// Host-side command transmitter: sends a 16-bit command as two
// UART bytes, high first, then collects one response byte.
module remote_cmd_tx
  import comm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DFLT_TIMEOUT,
  parameter int unsigned BAUD_DIV       = DFLT_BAUD_DIV
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        resp_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);

  comm_state_t state_q, state_d;

  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0]    low_q;
  logic [7:0]    resp_q;
  logic          cmd_snt_q;
  logic          resp_rdy_q;
  logic          resp_timeout_q;

  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       rx_rdy;
  logic       clr_rx_rdy;
  logic [7:0] rx_data;

  logic accept;
  logic snt_set;
  logic rsp_set;
  logic to_set;
  logic tmr_hit;

  UART #(
    .BAUD_DIV(BAUD_DIV)
  ) iUART (
    .clk       (clk),
    .rst_n     (rst_n),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .TX        (TX),
    .tx_done   (tx_done),
    .RX        (RX),
    .clr_rx_rdy(clr_rx_rdy),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data)
  );

  assign tmr_hit = (tmr_q == TMR_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (snd_cmd) state_d = HIGH;
      HIGH: if (tx_done) state_d = LOW;
      LOW:  if (tx_done) state_d = RESP;
      RESP: if (rx_rdy || tmr_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; a response beats a same-cycle timeout
  always_comb begin
    trmt    = 1'b0;
    accept  = 1'b0;
    snt_set = 1'b0;
    rsp_set = 1'b0;
    to_set  = 1'b0;
    unique case (state_q)
      IDLE: begin
        accept = snd_cmd;
        trmt   = snd_cmd;
      end
      HIGH: trmt = tx_done;
      LOW:  snt_set = tx_done;
      RESP: begin
        rsp_set = rx_rdy;
        to_set  = !rx_rdy && tmr_hit;
      end
      default: ;
    endcase
  end

  assign tx_data    = (state_q == IDLE) ? cmd[15:8] : low_q;
  assign clr_rx_rdy = rx_rdy;
  assign tmr_d      = ((state_q == RESP) && (state_d == RESP))
                      ? tmr_q + TW'(1) : '0;

  // Response timer, zero outside RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmr_q <= '0;
    else
      tmr_q <= tmr_d;
  end

  // Low-byte holding register and response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q  <= '0;
      resp_q <= '0;
    end else begin
      if (accept)
        low_q <= cmd[7:0];
      if (rsp_set)
        resp_q <= rx_data;
    end
  end

  // Status flags; set wins over consumer clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_snt_q      <= 1'b0;
      resp_rdy_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      if (accept)
        cmd_snt_q <= 1'b0;
      else if (snt_set)
        cmd_snt_q <= 1'b1;

      if (rsp_set)
        resp_rdy_q <= 1'b1;
      else if (accept || clr_resp_rdy)
        resp_rdy_q <= 1'b0;

      if (accept)
        resp_timeout_q <= 1'b0;
      else if (to_set)
        resp_timeout_q <= 1'b1;
    end
  end

  assign busy         = (state_q != IDLE);
  assign cmd_snt      = cmd_snt_q;
  assign resp         = resp_q;
  assign resp_rdy     = resp_rdy_q;
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Bench for remote_cmd_tx: TX frame monitor, RX responder and a
// timeline model of the status outputs checked every cycle.
module tb_remote_cmd_tx;
  import comm_pkg::*;

  localparam int B = 8;
  localparam int T = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        RX = 1'b1;
  logic        clr_resp_rdy = 1'b0;
  logic        TX;
  logic        busy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        resp_timeout;

  remote_cmd_tx #(
    .TIMEOUT_CYCLES(T),
    .BAUD_DIV      (B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .snd_cmd     (snd_cmd),
    .cmd         (cmd),
    .RX          (RX),
    .TX          (TX),
    .busy        (busy),
    .cmd_snt     (cmd_snt),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .clr_resp_rdy(clr_resp_rdy),
    .resp_timeout(resp_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  bit txn = 0, to_mode = 0, rsp_done = 0, win = 0, chk_on = 0;
  int t_start = 0, t_snt = 0;
  logic [7:0] m_resp = '0;
  bit m_rdy = 0;

  logic [7:0] mon_q[$];
  int         mon_t[$];
  logic [7:0] mon_b;

  bit e_snt, e_to, e_busy;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the transaction timeline
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      e_snt  = txn && (cyc >= t_snt);
      e_to   = txn && to_mode && (cyc >= t_snt + T);
      e_busy = txn && (to_mode ? (cyc < t_snt + T) : !rsp_done);
      chk("cmd_snt", cmd_snt, e_snt);
      chk("resp_timeout", resp_timeout, e_to);
      if (!win) begin
        chk("busy", busy, e_busy);
        chk("resp", resp, m_resp);
        chk("resp_rdy", resp_rdy, m_rdy);
      end
    end
  end

  // TX line decoder
  initial forever begin
    wait_cyc(1);
    if (rst_n && TX === 1'b0) begin
      mon_t.push_back(cyc);
      wait_cyc(B / 2);
      for (int i = 0; i < 8; i++) begin
        wait_cyc(B);
        mon_b[i] = TX;
      end
      wait_cyc(B);
      chk("tx_stop", TX, 1);
      mon_q.push_back(mon_b);
    end
  end

  task automatic send_byte(logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      wait_cyc(B);
    end
  endtask

  task automatic issue(logic [15:0] c, bit tmo);
    snd_cmd = 1'b1;
    cmd = c;
    wait_cyc(1);
    snd_cmd = 1'b0;
    t_start = cyc;
    t_snt = cyc + 20 * B + 2;
    txn = 1;
    to_mode = tmo;
    rsp_done = 0;
    m_rdy = 0;
  endtask

  task automatic pulse_clr();
    clr_resp_rdy = 1'b1;
    wait_cyc(1);
    clr_resp_rdy = 1'b0;
    m_rdy = 0;
  endtask

  task automatic run_txn(logic [15:0] c, bit rsp,
                         logic [7:0] rb, bit drop);
    int n;
    mon_q.delete();
    mon_t.delete();
    issue(c, !rsp);
    chk("busy_rise", busy, 1);
    chk("to_clr", resp_timeout, 0);
    if (drop) begin
      wait_cyc(20);
      snd_cmd = 1'b1;
      cmd = 16'h1234;
      wait_cyc(1);
      snd_cmd = 1'b0;
    end
    n = 0;
    while (!cmd_snt && n < 20 * B + 40) begin
      wait_cyc(1);
      n++;
    end
    chk("snt_lat", cyc - t_start, 20 * B + 2);
    chk("tx_nbytes", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      chk("tx_hi", mon_q[0], c[15:8]);
      chk("tx_lo", mon_q[1], c[7:0]);
      chk("frame_gap", mon_t[1] - mon_t[0], 10 * B + 1);
    end
    if (rsp) begin
      wait_cyc($urandom_range(0, 15));
      win = 1;
      send_byte(rb);
      n = 0;
      while (!resp_rdy && n < 8) begin
        wait_cyc(1);
        n++;
      end
      chk("resp_val", resp, rb);
      chk("resp_rdy_set", resp_rdy, 1);
      m_resp = rb;
      m_rdy = 1;
      rsp_done = 1;
      wait_cyc(1);
      win = 0;
    end else begin
      n = 0;
      while (!resp_timeout && n < T + 20) begin
        wait_cyc(1);
        n++;
      end
      chk("to_lat", cyc - t_snt, T);
      chk("to_busy", busy, 0);
    end
  endtask

  initial begin
    logic [15:0] rc;
    logic [7:0]  rb;
    wait_cyc(3);
    chk("rst_TX", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_snt", cmd_snt, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_rdy", resp_rdy, 0);
    chk("rst_to", resp_timeout, 0);
    rst_n = 1'b1;
    wait_cyc(2);
    chk_on = 1;

    run_txn(16'h2B4C, 1, RESP_ACK, 0);
    chk("lit_2B", (mon_q.size() > 0) ? mon_q[0] : 8'hxx, 8'h2B);
    chk("lit_A5", resp, 8'hA5);
    pulse_clr();
    wait_cyc(1);
    chk("clr_rdy", resp_rdy, 0);
    chk("clr_hold", resp, 8'hA5);

    run_txn(16'h1357, 0, 8'h00, 0);
    chk("lit_to", resp_timeout, 1);

    run_txn(16'hBEEF, 1, 8'h3C, 1);
    wait_cyc(5);

    send_byte(8'h77);
    wait_cyc(4);
    chk("stray_resp", resp, 8'h3C);
    chk("stray_rdy", resp_rdy, 1);

    run_txn(16'h0001, 1, RESP_NACK, 0);
    chk("lit_5A", resp, 8'h5A);

    mon_q.delete();
    issue(16'h9999, 0);
    wait_cyc(3 * B);
    rst_n = 1'b0;
    wait_cyc(2);
    chk("mid_TX", TX, 1);
    chk("mid_busy", busy, 0);
    chk("mid_snt", cmd_snt, 0);
    chk("mid_resp", resp, 8'h00);
    chk("mid_rdy", resp_rdy, 0);
    chk("mid_to", resp_timeout, 0);
    txn = 0;
    m_resp = '0;
    m_rdy = 0;
    rst_n = 1'b1;
    wait_cyc(12 * B);
    run_txn(16'hC3C3, 1, 8'hA5, 0);

    for (int k = 0; k < 10; k++) begin
      rc = 16'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        send_byte(8'($urandom));
        wait_cyc(3);
      end
      if ($urandom_range(0, 1) == 0)
        pulse_clr();
      run_txn(rc, $urandom_range(0, 3) != 0, rb,
              $urandom_range(0, 4) == 0);
      wait_cyc($urandom_range(1, 10));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/remote_cmd_tx.md
# remote_cmd_tx

Host-side command transmitter and response collector for the serial command link. It takes a 16-bit command from the bench or host logic and sends it over the UART TX line as two bytes, high byte first. It then waits for the single response byte returned by the far end and presents it with a ready flag. A response timeout is reported if nothing comes back. It is the initiator peer of the design's command-receive path and shares the same UART core and framing.

## Interface
- TIMEOUT_CYCLES, 5_000_000: clk cycles allowed between `cmd_snt` rising and response byte arrival (100 ms at 50 MHz); must be ≥ 2.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- snd_cmd  in  1  single-cycle request to transmit `cmd`; ignored while `busy`.
- cmd  in  16  command word; sampled only in the cycle `snd_cmd` is accepted.
- RX  in  1  UART receive line from far end.
- TX  out  1  UART transmit line to far end; idles high.
- busy  out  1  high whenever state ≠ IDLE.
- cmd_snt  out  1  set when the low byte's stop bit completes; cleared on next accepted `snd_cmd`.
- resp  out  8  last accepted response byte; holds until the next accepted response.
- resp_rdy  out  1  new response available.
- clr_resp_rdy  in  1  consumer acknowledge; clears `resp_rdy`.
- resp_timeout  out  1  set when TIMEOUT_CYCLES elapse in RESP with no byte; cleared on next accepted `snd_cmd`.

## Operation
- Embedded UART core signals: `trmt`, `tx_data[7:0]`, `tx_done`, `rx_rdy`, `clr_rx_rdy`, `rx_data[7:0]`. `tx_done` is sticky: set at the end of the stop bit, cleared by `trmt`.
- `tx_data` mux: in IDLE it is `cmd[15:8]` (live input); otherwise it is `low_q`.
- States: IDLE, HIGH, LOW, RESP.
- IDLE:
  - On `snd_cmd`: assert `trmt` in the same cycle, latch `low_q <= cmd[7:0]`, clear `cmd_snt`, `resp_rdy` and `resp_timeout`, then go to HIGH.
- HIGH:
  - On `tx_done`: assert `trmt` for one cycle, then go to LOW.
- LOW:
  - On `tx_done`: set `cmd_snt`, clear the timer, then go to RESP.
- RESP:
  - Timer increments every cycle.
  - On `rx_rdy`: load `resp <= rx_data`, set `resp_rdy`, pulse `clr_rx_rdy`, then go to IDLE.
  - Otherwise, when timer == TIMEOUT_CYCLES−1: set `resp_timeout`, then go to IDLE.
  - `rx_rdy` and the timeout in the same cycle: the response wins and `resp_timeout` stays 0.
- Stray bytes (`rx_rdy` in IDLE, HIGH or LOW) are discarded: `clr_rx_rdy` is pulsed and `resp` and `resp_rdy` are unchanged.
- `snd_cmd` while `busy` is dropped, with no queuing.
- `resp_rdy` SR flop: set has priority over `clr_resp_rdy` in the same cycle. A clear arriving in any other cycle clears it.
- Timer width is `$clog2(TIMEOUT_CYCLES)`. It is held at 0 outside RESP and never wraps.

## Timing
- Reset values: state IDLE, `TX`=1, `busy`=0, `cmd_snt`=0, `resp`=8'h00, `resp_rdy`=0, `resp_timeout`=0, timer 0, `low_q`=0.
- `trmt` for the high byte is asserted combinationally in the `snd_cmd` cycle, so the start bit begins per the UART core's latency.
- `busy` rises on the clock edge after `snd_cmd`.
- Inter-byte gap: one clk between `tx_done` and `trmt`, so the two frames are back-to-back.
- Total transmit time is 20 bit-times plus 2 clk.
- `resp_rdy` rises one clk after `rx_rdy` is seen in RESP.
- `resp_timeout` rises TIMEOUT_CYCLES clk after `cmd_snt` rises.
- An async reset mid-frame aborts the transfer immediately. `TX` returns high, and the next `snd_cmd` starts cleanly.

## Structure
- Shared package `comm_pkg`: `comm_state_t` enum {IDLE, HIGH, LOW, RESP}, `RESP_ACK = 8'hA5`, `RESP_NACK = 8'h5A`, default timeout constant.
- One sub-module: the existing `UART` core (tx + rx), instantiated as `iUART`.
- The remainder is one module: SM, `low_q`, `resp` register, three SR flops, and the timer.

## Test plan
- Reset, then `cmd`=16'h2B4C with one `snd_cmd` pulse: TX carries frames 0x2B then 0x4C with no idle gap, `cmd_snt` rises after the second stop bit, and `busy` stays high through RESP.
- Bench responder UART returns 0xA5 after `cmd_snt`: `resp`=8'hA5 and `resp_rdy`=1 one clk after rx; `clr_resp_rdy` then drops `resp_rdy` while `resp` holds 0xA5.
- TIMEOUT_CYCLES=1000, no response: `resp_timeout`=1 exactly 1000 clk after `cmd_snt`, state IDLE; the next `snd_cmd` clears `resp_timeout`.
- `snd_cmd` with 16'h1234 pulsed during HIGH of a 16'hBEEF send: only 0xBE and 0xEF appear on TX, and the second request is dropped.
- Responder sends a stray 0x77 while the DUT is in IDLE: `resp` and `resp_rdy` are unchanged and the core's rx flag is cleared. Then send 16'h0001 and respond 0x5A: `resp`=8'h5A.
- Assert `rst_n` low mid-way through the high byte: `TX`=1 and all outputs reset; after release, 16'hC3C3 is transmitted correctly.
